// File: rtl/imm_gen_pkg.sv
// Shared format encodings and defaults for the pipelined immediate generator.
// Encoding IMM_Z is only legal when IMM_GEN_CSR_EN is defined.
package imm_gen_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int TAG_W_DEFAULT = 5;
    localparam int CNT_W_DEFAULT = 8;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_Z = 3'b101;

endpackage

// File: rtl/imm_gen_fmt.sv
// Combinational immediate extraction from instr[31:7]; every format sign-extends from bit 31.
// IMM_GEN_CSR_EN enables the zero-extended CSR uimm (Z) format on encoding 101.
module imm_gen_fmt
    import imm_gen_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [24:0]     in_imm,
    input  logic [2:0]      in_src,
    output logic [XLEN-1:0] imm,
    output logic            ill
);

    logic [31:7] ins;
    logic [31:0] v;

    assign ins = in_imm;

    // Z has bit 31 clear, so the common sign-fill below zero-extends it for free.
    always_comb begin
        v   = '0;
        ill = 1'b0;
        case (in_src)
            IMM_I: v = {{20{ins[31]}}, ins[31:20]};
            IMM_S: v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J: v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U: v = {ins[31:12], 12'b0};
`ifdef IMM_GEN_CSR_EN
            IMM_Z: v = {27'b0, ins[19:15]};
`endif
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        imm       = {XLEN{v[31]}};
        imm[31:0] = v;
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready on both sides, a 1-entry skid buffer
// and a saturating illegal-format counter. IMM_GEN_CSR_EN enables the Z (CSR uimm) format.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_imm,
    input  logic [2:0]       in_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ill,
    input  logic             ill_clr,
    output logic [CNT_W-1:0] ill_cnt
);

    logic [XLEN-1:0]  fmt_imm;
    logic             fmt_ill;

    logic             skid_valid;
    logic             skid_valid_nxt;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;

    logic             accept;
    logic             out_load;

    imm_gen_fmt #(.XLEN(XLEN)) u_fmt (
        .in_imm (in_imm),
        .in_src (in_src),
        .imm    (fmt_imm),
        .ill    (fmt_ill)
    );

    assign accept   = in_valid && in_ready;
    assign out_load = !out_valid || out_ready;

    // in_ready is low whenever the skid holds data, so accept and skid_valid never coincide.
    always_comb begin
        skid_valid_nxt = skid_valid;
        if (skid_valid && out_load) begin
            skid_valid_nxt = 1'b0;
        end else if (accept && !out_load) begin
            skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_ill   <= 1'b0;
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_tag    <= '0;
            out_ill    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_nxt;
            in_ready   <= !skid_valid_nxt;

            if (accept && !out_load) begin
                skid_imm <= fmt_imm;
                skid_tag <= in_tag;
                skid_ill <= fmt_ill;
            end

            if (out_load) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_imm   <= skid_imm;
                    out_tag   <= skid_tag;
                    out_ill   <= skid_ill;
                end else if (accept) begin
                    out_valid <= 1'b1;
                    out_imm   <= fmt_imm;
                    out_tag   <= in_tag;
                    out_ill   <= fmt_ill;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // A clear coinciding with an illegal accept counts that accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_cnt <= '0;
        end else if (ill_clr) begin
            ill_cnt <= (accept && fmt_ill) ? CNT_W'(1) : '0;
        end else if (accept && fmt_ill && !(&ill_cnt)) begin
            ill_cnt <= ill_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream,
// checked against a queue-based reference model. Honours IMM_GEN_CSR_EN.
module tb_imm_gen_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [24:0] in_imm;
    logic [2:0]  in_src;
    logic [4:0]  in_tag;
    logic        out_ready;
    logic        ill_clr;

    logic        in_ready,  in_ready64;
    logic        out_valid, out_valid64;
    logic [31:0] out_imm;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag,   out_tag64;
    logic        out_ill,   out_ill64;
    logic [7:0]  ill_cnt,   ill_cnt64;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   cnt_model = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_src(in_src), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_ill(out_ill),
        .ill_clr(ill_clr), .ill_cnt(ill_cnt)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_imm(in_imm), .in_src(in_src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_ill(out_ill64),
        .ill_clr(ill_clr), .ill_cnt(ill_cnt64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V immediate rules evaluated as signed integers.
    function automatic logic [63:0] ref_imm(input logic [24:0] f, input logic [2:0] src,
                                            output logic ill);
        logic [31:0] i;
        longint      v;
        i   = {f, 7'b0};
        v   = 0;
        ill = 1'b0;
        case (src)
            3'd0: v = longint'($signed(i[31:20]));
            3'd1: v = longint'($signed({i[31:25], i[11:7]}));
            3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd3: v = longint'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd4: v = longint'($signed({i[31:12], 12'b0}));
`ifdef IMM_GEN_CSR_EN
            3'd5: v = longint'({27'b0, i[19:15]});
`endif
            default: ill = 1'b1;
        endcase
        return 64'(v);
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic tick();
        exp_t        e;
        logic        acc, take, ill;
        logic [63:0] v;
        chk("in_ready",    64'(in_ready),    64'(q.size() < 2));
        chk("in_ready64",  64'(in_ready64),  64'(q.size() < 2));
        chk("out_valid",   64'(out_valid),   64'(q.size() > 0));
        chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
        if (q.size() > 0) begin
            chk("out_imm",   64'(out_imm),   64'(q[0].imm[31:0]));
            chk("out_imm64", out_imm64,      q[0].imm);
            chk("out_tag",   64'(out_tag),   64'(q[0].tag));
            chk("out_tag64", 64'(out_tag64), 64'(q[0].tag));
            chk("out_ill",   64'(out_ill),   64'(q[0].ill));
        end
        chk("ill_cnt",   64'(ill_cnt),   64'(cnt_model));
        chk("ill_cnt64", 64'(ill_cnt64), 64'(cnt_model));
        acc  = in_valid && (q.size() < 2);
        take = (q.size() > 0) && out_ready;
        v    = ref_imm(in_imm, in_src, ill);
        @(posedge clk);
        if (take) void'(q.pop_front());
        if (acc) begin
            e.imm = v; e.tag = in_tag; e.ill = ill;
            q.push_back(e);
        end
        if (ill_clr)        cnt_model = (acc && ill) ? 1 : 0;
        else if (acc && ill) cnt_model = (cnt_model < 255) ? cnt_model + 1 : 255;
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [2:0] src,
                         input logic [4:0] tag);
        in_valid = v;
        in_imm   = instr[31:7];
        in_src   = src;
        in_tag   = tag;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(in_ready),  64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_imm",   out_imm64,      64'(0));
        chk("rst_out_tag",   64'(out_tag),   64'(0));
        chk("rst_out_ill",   64'(out_ill),   64'(0));
        chk("rst_ill_cnt",   64'(ill_cnt),   64'(0));
        q.delete();
        cnt_model = 0;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_in_ready",  64'(in_ready),  64'(1));
        chk("post_rst_out_valid", 64'(out_valid), 64'(0));
    endtask

    // Single accept from idle with out_ready high; result must appear the very next cycle.
    task automatic directed(input string name, input logic [31:0] instr, input logic [2:0] src,
                            input logic [63:0] exp64, input logic exp_ill);
        out_ready = 1'b1;
        drive(1'b1, instr, src, 5'd9);
        tick();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        chk({name, "_valid"}, 64'(out_valid), 64'(1));
        chk({name, "_imm32"}, 64'(out_imm),   64'(exp64[31:0]));
        chk({name, "_imm64"}, out_imm64,      exp64);
        chk({name, "_ill"},   64'(out_ill),   64'(exp_ill));
        tick();
    endtask

    initial begin
        int sent;
        int budget;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_src    = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        ill_clr   = 1'b0;
        @(negedge clk);
        do_reset();

        directed("addi", 32'hFFF00093, 3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        directed("beq",  32'hFE000EE3, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        directed("lui",  32'h123452B7, 3'b100, 64'h0000_0000_1234_5000, 1'b0);
        directed("jal",  32'h0010006F, 3'b011, 64'h0000_0000_0000_0800, 1'b0);
`ifdef IMM_GEN_CSR_EN
        directed("csr",  32'h3401D073, 3'b101, 64'h0000_0000_0000_0003, 1'b0);
`else
        directed("csr",  32'h3401D073, 3'b101, 64'h0, 1'b1);
`endif

        // Six back-to-back requests under random backpressure.
        sent = 0;
        budget = 0;
        while (sent < 6 && budget < 200) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 4)), 5'(sent + 1));
            out_ready = 1'($urandom);
            if (q.size() < 2) sent++;
            tick();
            budget++;
        end
        chk("stream_all_sent", 64'(sent), 64'(6));
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        budget = 0;
        while (q.size() > 0 && budget < 50) begin
            out_ready = 1'($urandom);
            tick();
            budget++;
        end
        chk("stream_drained", 64'(q.size()), 64'(0));

        // Saturate the illegal counter.
        out_ready = 1'b1;
        for (int k = 0; k < 260; k++) begin
            drive(1'b1, $urandom, 3'(6 + ($urandom % 2)), 5'(k));
            tick();
        end
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        tick();
        chk("ill_cnt_sat", 64'(ill_cnt), 64'(255));
        directed("ill111", $urandom, 3'b111, 64'h0, 1'b1);
        chk("ill_cnt_hold", 64'(ill_cnt), 64'(255));
        ill_clr = 1'b1;
        drive(1'b1, $urandom, 3'b110, 5'd3);
        tick();
        ill_clr = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        chk("ill_clr_acc", 64'(ill_cnt), 64'(1));
        ill_clr = 1'b1;
        tick();
        ill_clr = 1'b0;
        chk("ill_clr_alone", 64'(ill_cnt), 64'(0));
        tick();

        // Random mixed traffic.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom), $urandom, 3'($urandom % 8), 5'($urandom));
            out_ready = ($urandom % 4) != 0;
            ill_clr   = ($urandom % 16) == 0;
            tick();
        end
        ill_clr = 1'b0;

        // Fill both entries, then reset mid-transfer.
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        out_ready = 1'b1;
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            tick();
            budget++;
        end
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'b000, 5'd21);
        tick();
        drive(1'b1, 32'h123452B7, 3'b100, 5'd22);
        tick();
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        chk("full_in_ready", 64'(in_ready), 64'(0));
        chk("full_q", 64'(q.size()), 64'(2));
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
